alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: none; data width fixed at 16 bits, op width fixed at 2 bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: req0  input  1  requester 0 operation request; held high until gnt0.
REQ-005 Port: op0  input  2  requester 0 operation code.
REQ-006 Port: a0, b0  input  16 each  requester 0 operands (i0, i1).
REQ-007 Port: req1, op1, a1, b1  input  1/2/16/16  requester 1 equivalents.
REQ-008 Port: gnt0, gnt1  output  1 each  one-cycle grant pulse; operands latched in this cycle.
REQ-009 Port: done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 Port: res  output  16  registered ALU result; valid when done0 or done1 is high, held until the next completion.
REQ-011 Port: cout_q  output  1  registered carry flag accompanying res.

Function
REQ-012 The block SHALL share one internal 16-bit ALU instance between two requesters.
REQ-013 Op encoding SHALL be: 00 AND, 10 OR, 01 and 11 SUB (i0 - i1, two's complement).
REQ-014 cout_q SHALL equal the ALU carry-out for SUB (1 = no borrow) and SHALL be 0 for AND/OR.
REQ-015 FSM states SHALL be IDLE, EXEC, DONE; encoding is free.
REQ-016 IDLE: if no request is pending, the FSM SHALL stay in IDLE with all pulses low.
REQ-017 IDLE with a request: the FSM SHALL select a winner, assert its gnt for exactly that cycle, latch its op/a/b into internal registers, and go to EXEC next cycle.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one request high, that requester wins.
REQ-019 After reset, the last-granted pointer SHALL be 1, so requester 0 wins the first tie.
REQ-020 EXEC: the ALU SHALL be driven only from the latched registers, never from live inputs. res/cout_q SHALL be registered at the end of EXEC, and the FSM SHALL go to DONE.
REQ-021 DONE: the block SHALL assert the winner's done for one cycle, update the last-granted pointer, and return to IDLE.
REQ-022 Latency SHALL be fixed: gnt in cycle N, done in cycle N+2, earliest next gnt in cycle N+3.
REQ-023 Operand or req changes after gnt SHALL NOT affect the in-flight result.
REQ-024 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-025 gnt0/gnt1 SHALL never be high together; the same SHALL hold for done0/done1.

Reset
REQ-026 On reset, the FSM SHALL enter IDLE; gnt0, gnt1, done0, done1 SHALL be 0; res SHALL be 16'h0000; cout_q SHALL be 0; the pointer SHALL be 1; latched operands SHALL be cleared.
REQ-027 Reset during EXEC or DONE SHALL abort the operation with no done pulse; the next cycle SHALL behave as post-reset IDLE.
REQ-028 Reset SHALL take priority over every other state transition in the same cycle.

Structure
REQ-029 A shared package SHALL hold the op constants (OP_AND, OP_OR, OP_SUB) and the FSM state type/constants.
REQ-030 The existing 16-bit ALU module (alu: op, i0, i1 -> o, cout) SHALL be the single sub-module instance; no second ALU is permitted.

Verification
REQ-031 Req0 op=00, a0=16'h1234, b0=16'h00FF -> gnt0 at N, done0 at N+2, res=16'h0034, cout_q=0.
REQ-032 Req1 op=01, a1=16'h0005, b1=16'h0003 -> done1, res=16'h0002, cout_q=1. Then a1=16'h0003, b1=16'h0005 -> res=16'hFFFE, cout_q=0.
REQ-033 Req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1 at 3-cycle spacing; gnt never overlaps.
REQ-034 Req0 op=10, a0=16'hF000, b0=16'h000F; change a0 to 16'h0000 one cycle after gnt0 -> res=16'hF00F.
REQ-035 Assert reset in the EXEC cycle -> no done pulse, res=16'h0000, FSM in IDLE; a fresh req0 afterwards -> gnt0 (pointer reset).

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared ALU op codes, data width and arbiter FSM state type
package alu_arb_pkg;
  localparam int W = 16;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b01;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu.sv
// alu: 16-bit AND/OR/SUB unit; op[0] selects SUB, cout is the no-borrow flag
module alu
  import alu_arb_pkg::*;
(
  input  logic [1:0]   op,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  output logic [W-1:0] o,
  output logic         cout
);
  logic [W:0] sum;
  // subtract as i0 + ~i1 + 1 so the top bit is the carry-out
  always_comb begin
    sum  = {1'b0, i0} + {1'b0, ~i1} + {{W{1'b0}}, 1'b1};
    o    = op == OP_AND ? i0 & i1 : op == OP_OR ? i0 | i1 : sum[W-1:0];
    cout = op[0] & sum[W];
  end
endmodule

// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one ALU between two requesters
module alu_arb
  import alu_arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         cout_q
);
  state_t state_q, state_d;
  logic ptr_q, ptr_d, win_q, win_d, cout_d, alu_c, any, w;
  logic [1:0] op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_o;
  alu u_alu (.op(op_q), .i0(a_q), .i1(b_q), .o(alu_o), .cout(alu_c));
  // next state, operand capture, result capture; pulses are masked while reset is high
  always_comb begin
    any     = req0 | req1;
    w       = req1 & (~req0 | ~ptr_q);
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (any) begin
        win_d   = w;
        op_d    = w ? op1 : op0;
        a_d     = w ? a1 : a0;
        b_d     = w ? b1 : b0;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_o;
        cout_d  = alu_c;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gnt0  = ~reset & (state_q == IDLE) & any & ~w;
    gnt1  = ~reset & (state_q == IDLE) & any & w;
    done0 = ~reset & (state_q == DONE) & ~win_q;
    done1 = ~reset & (state_q == DONE) & win_q;
  end
  // state registers; the pointer resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      win_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end
  assign res = res_q;
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: table, directed and random checks of the shared-ALU arbiter
module tb_alu_arb;
  typedef struct {
    logic r0; logic [1:0] op0; logic [15:0] a0, b0;
    logic r1; logic [1:0] op1; logic [15:0] a1, b1;
    logic w; logic [15:0] res; logic c;
  } vec_t;

  logic clk, reset, req0, req1, gnt0, gnt1, done0, done1, cout_q;
  logic [1:0] op0, op1;
  logic [15:0] a0, b0, a1, b1, res;
  int n_cmp, n_err;
  logic last;
  vec_t tbl[7];

  alu_arb dut (.clk(clk), .reset(reset), .req0(req0), .op0(op0), .a0(a0), .b0(b0),
               .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
               .done0(done0), .done1(done1), .res(res), .cout_q(cout_q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 2'b00) return {1'b0, a & b};
    if (op == 2'b10) return {1'b0, a | b};
    return {a >= b, 16'(a - b)};
  endfunction

  function automatic logic model_w(input logic r0, input logic r1);
    return (r0 && r1) ? ~last : r1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; op0 = v.op0; a0 = v.a0; b0 = v.b0;
    req1 = v.r1; op1 = v.op1; a1 = v.a1; b1 = v.b1;
  endtask

  task automatic do_txn(input vec_t v, input bit hold, input bit scr,
                        input logic ew, input logic [15:0] eres, input logic ec);
    drive(v);
    @(negedge clk);
    chk("gnt0", gnt0, !ew);
    chk("gnt1", gnt1, ew);
    chk("idle_done", {done0, done1}, 0);
    step();
    if (!hold) begin req0 = 0; req1 = 0; end
    if (scr) begin
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      op0 = 2'($urandom); op1 = 2'($urandom);
    end
    @(negedge clk);
    chk("exec_pulses", {gnt0, gnt1, done0, done1}, 0);
    step();
    @(negedge clk);
    chk("done0", done0, !ew);
    chk("done1", done1, ew);
    chk("done_gnt", {gnt0, gnt1}, 0);
    chk("res", res, eres);
    chk("cout", cout_q, ec);
    step();
    last = ew;
  endtask

  initial begin
    vec_t v;
    logic w;
    logic [16:0] e;
    n_cmp = 0; n_err = 0;
    reset = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tbl[0] = '{1, 2'b00, 16'h1234, 16'h00FF, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0034, 0};
    tbl[1] = '{0, 2'b00, 16'h0, 16'h0, 1, 2'b01, 16'h0005, 16'h0003, 1, 16'h0002, 1};
    tbl[2] = '{0, 2'b00, 16'h0, 16'h0, 1, 2'b01, 16'h0003, 16'h0005, 1, 16'hFFFE, 0};
    tbl[3] = '{1, 2'b10, 16'hF000, 16'h000F, 0, 2'b00, 16'h0, 16'h0, 0, 16'hF00F, 0};
    tbl[4] = '{1, 2'b00, 16'hFFFF, 16'h0F0F, 1, 2'b11, 16'h0000, 16'h0001, 1, 16'hFFFF, 0};
    tbl[5] = '{1, 2'b01, 16'h8000, 16'h7FFF, 1, 2'b10, 16'h1111, 16'h2222, 0, 16'h0001, 1};
    tbl[6] = '{0, 2'b00, 16'h0, 16'h0, 1, 2'b01, 16'h1234, 16'h1234, 1, 16'h0000, 1};
    step(); step();
    @(negedge clk);
    chk("rst_pulses", {gnt0, gnt1, done0, done1}, 0);
    chk("rst_res", res, 0);
    chk("rst_cout", cout_q, 0);
    step();
    reset = 0;
    last = 1;
    @(negedge clk);
    chk("idle_noreq", {gnt0, gnt1, done0, done1}, 0);
    step();
    foreach (tbl[i]) do_txn(tbl[i], 0, 1, tbl[i].w, tbl[i].res, tbl[i].c);
    v = '{1, 2'b01, 16'h0009, 16'h0004, 1, 2'b10, 16'h00A0, 16'h0005, 0, 16'h0, 0};
    for (int k = 0; k < 6; k++) begin
      w = model_w(1, 1);
      e = w ? ref_alu(v.op1, v.a1, v.b1) : ref_alu(v.op0, v.a0, v.b0);
      chk("alternate", w, k[0]);
      do_txn(v, 1, 0, w, e[15:0], e[16]);
    end
    req0 = 0; req1 = 0;
    step(); step();
    for (int k = 0; k < 40; k++) begin
      v.r0 = 1'($urandom); v.r1 = 1'($urandom);
      if (!v.r0 && !v.r1) v.r0 = 1;
      v.op0 = 2'($urandom); v.op1 = 2'($urandom);
      v.a0 = 16'($urandom); v.a1 = 16'($urandom);
      v.b0 = ($urandom_range(0, 3) == 0) ? v.a0 : 16'($urandom);
      v.b1 = ($urandom_range(0, 3) == 0) ? v.a1 : 16'($urandom);
      w = model_w(v.r0, v.r1);
      e = w ? ref_alu(v.op1, v.a1, v.b1) : ref_alu(v.op0, v.a0, v.b0);
      do_txn(v, 0, 1, w, e[15:0], e[16]);
      if (k % 5 == 4) begin
        @(negedge clk);
        chk("rand_idle", {gnt0, gnt1, done0, done1}, 0);
        step();
      end
    end
    do_txn(tbl[0], 0, 0, 0, 16'h0034, 0);
    req0 = 1; op0 = 2'b01; a0 = 16'h0007; b0 = 16'h0001;
    @(negedge clk);
    chk("abort_gnt0", gnt0, 1);
    step();
    req0 = 0; reset = 1;
    @(negedge clk);
    chk("abort_exec", {done0, done1}, 0);
    step();
    reset = 0; last = 1;
    @(negedge clk);
    chk("abort_pulses", {gnt0, gnt1, done0, done1}, 0);
    chk("abort_res", res, 0);
    chk("abort_cout", cout_q, 0);
    step();
    @(negedge clk);
    chk("abort_nodone", {done0, done1}, 0);
    step();
    v = '{1, 2'b10, 16'h0F00, 16'h00F0, 1, 2'b00, 16'hFFFF, 16'hFFFF, 0, 16'h0FF0, 0};
    do_txn(v, 0, 0, model_w(1, 1), 16'h0FF0, 0);
    req1 = 1; op1 = 2'b01; a1 = 16'h0010; b1 = 16'h0001;
    @(negedge clk);
    chk("abort2_gnt1", gnt1, 1);
    step();
    req1 = 0;
    step();
    reset = 1;
    @(negedge clk);
    chk("abort_done_cycle", {done0, done1}, 0);
    step();
    reset = 0; last = 1;
    @(negedge clk);
    chk("abort2_res", res, 0);
    chk("abort2_pulses", {gnt0, gnt1, done0, done1}, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
